// File: rtl/text_inject_pkg.sv
// text_inject shared types and constants.
// State encoding plus the ASCII codes the translator keys on.
package text_inject_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_XLATE,
    S_PRESENT,
    S_GAP
  } state_t;

  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_LF  = 8'h0A;
  localparam logic [7:0] ASC_TAB = 8'h09;
  localparam logic [7:0] ASC_DEL = 8'h7F;
  localparam logic [7:0] ASC_SP  = 8'h20;
  localparam logic [7:0] KBD_HI  = 8'h80;

endpackage

// File: rtl/text_inject_ram.sv
// Text buffer: one write port, one registered read port.
// Read data appears one clock after the address is presented.
module text_inject_ram #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  // Byte write plus one-cycle-latency read
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_inject.sv
// Replays a downloaded text file into the Apple-1 keyboard path.
// Define TEXT_INJECT_CRLF_FOLD_EN to drop the LF of a CR,LF pair.
module text_inject
  import text_inject_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int CHAR_GAP = 25000,
  parameter int LINE_GAP = 2500000,
  parameter int GAP_W    = 24
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_data,
  output logic [7:0]        kbd_data,
  output logic              kbd_strobe,
  input  logic              kbd_ack,
  output logic              busy
);

  localparam logic [GAP_W-1:0] CG = GAP_W'(CHAR_GAP);
  localparam logic [GAP_W-1:0] LG = GAP_W'(LINE_GAP);

  state_t            state;
  logic              dl_q;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   ptr;
  logic [GAP_W-1:0]  gap;
  logic [7:0]        rdata;
  logic              we;
  logic              rise;
  logic [ADDR_W:0]   wr_end;
  logic [ADDR_W:0]   ptr_nx;
  logic [7:0]        c;
  logic [7:0]        xc;
  logic              skip;
  logic              ctl;
  logic              last_cr;

  assign rise   = ioctl_download & ~dl_q;
  assign we     = (state == S_LOAD) & ioctl_wr & ioctl_download;
  assign wr_end = {1'b0, ioctl_addr} + (ADDR_W+1)'(1);
  assign ptr_nx = ptr + (ADDR_W+1)'(1);
  assign c      = {1'b0, rdata[6:0]};
  assign ctl    = ((c < ASC_SP) && (c != ASC_LF) &&
                   (c != ASC_TAB) && (c != ASC_CR)) ||
                  (c == ASC_DEL);

  text_inject_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk25),
    .we    (we),
    .waddr (ioctl_addr),
    .wdata (ioctl_data),
    .raddr (ptr[ADDR_W-1:0]),
    .rdata (rdata)
  );

`ifdef TEXT_INJECT_CRLF_FOLD_EN
  // Remember whether the last translated source byte was a CR
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) last_cr <= 1'b0;
    else if (rise || state == S_LOAD) last_cr <= 1'b0;
    else if (state == S_XLATE) last_cr <= (c == ASC_CR);
  end
`else
  assign last_cr = 1'b0;
`endif

  // Map a source byte to a key code, or flag it for skipping
  always_comb begin
    xc   = c;
    skip = 1'b0;
    unique case (1'b1)
      (c == ASC_LF): begin
        xc   = ASC_CR;
        skip = last_cr;
      end
      (c == ASC_TAB): xc = ASC_SP;
      (c >= 8'h61 && c <= 8'h7A): xc = c - 8'h20;
      ctl: skip = 1'b1;
      default: ;
    endcase
  end

  // Load / fetch / present / pace sequencer
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      dl_q       <= 1'b0;
      len        <= '0;
      ptr        <= '0;
      gap        <= '0;
      kbd_data   <= 8'h00;
      kbd_strobe <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      if (rise) begin
        state      <= S_LOAD;
        len        <= '0;
        ptr        <= '0;
        kbd_strobe <= 1'b0;
        busy       <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: ;
          S_LOAD: begin
            if (!ioctl_download) begin
              ptr <= '0;
              if (len == '0) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= S_FETCH;
              end
            end else if (ioctl_wr && wr_end > len) begin
              len <= wr_end;
            end
          end
          S_FETCH: state <= S_XLATE;
          S_XLATE: begin
            if (skip) begin
              ptr <= ptr_nx;
              if (ptr_nx < len) begin
                state <= S_FETCH;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              kbd_data   <= xc | KBD_HI;
              kbd_strobe <= 1'b1;
              state      <= S_PRESENT;
            end
          end
          S_PRESENT: begin
            if (kbd_ack) begin
              kbd_strobe <= 1'b0;
              ptr        <= ptr_nx;
              gap        <= (kbd_data == (ASC_CR | KBD_HI)) ? LG : CG;
              state      <= S_GAP;
            end
          end
          S_GAP: begin
            if (gap != '0) begin
              gap <= gap - GAP_W'(1);
            end else if (ptr < len) begin
              state <= S_FETCH;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_text_inject.sv
// Directed bench for text_inject with shortened pacing gaps.
// Expected codes and cycle counts are worked out by hand.
module tb_text_inject;

  localparam int CG = 20;
  localparam int LG = 60;

  logic        clk25 = 1'b0;
  logic        rst_n = 1'b0;
  logic        dl    = 1'b0;
  logic        wr    = 1'b0;
  logic [12:0] addr  = '0;
  logic [7:0]  data  = '0;
  logic        ack   = 1'b0;
  logic [7:0]  kbd_data;
  logic        kbd_strobe;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int n;
  int s;
  int bad;
  logic [7:0] held;

  text_inject #(
    .ADDR_W   (13),
    .CHAR_GAP (CG),
    .LINE_GAP (LG),
    .GAP_W    (24)
  ) dut (
    .clk25          (clk25),
    .rst_n          (rst_n),
    .ioctl_download (dl),
    .ioctl_wr       (wr),
    .ioctl_addr     (addr),
    .ioctl_data     (data),
    .kbd_data       (kbd_data),
    .kbd_strobe     (kbd_strobe),
    .kbd_ack        (ack),
    .busy           (busy)
  );

  always #20 clk25 = ~clk25;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int k = 1);
    repeat (k) @(negedge clk25);
  endtask

  // Download up to four bytes; returns at the negedge where dl drops
  task automatic send(input int cnt,
                      input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] b [4];
    b = '{b0, b1, b2, b3};
    dl = 1'b1;
    cyc();
    for (int i = 0; i < cnt; i++) begin
      wr   = 1'b1;
      addr = 13'(i);
      data = b[i];
      cyc();
      wr = 1'b0;
    end
    dl = 1'b0;
  endtask

  task automatic wait_strobe(input int max, output int k);
    k = 0;
    while (!kbd_strobe && k < max) begin
      cyc();
      k++;
    end
  endtask

  task automatic wait_idle(input int max, output int k, output int st);
    k  = 0;
    st = 0;
    while (busy && k < max) begin
      cyc();
      k++;
      if (kbd_strobe) st++;
    end
  endtask

  task automatic press();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
  endtask

  initial begin
    cyc(2);
    check("rst_data", kbd_data, 8'h00);
    check("rst_strobe", kbd_strobe, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    cyc(2);

    // "a\n" with a long hold before the first ack
    send(2, 8'h61, 8'h0A, 8'h00, 8'h00);
    check("a_busy", busy, 1'b1);
    wait_strobe(50, n);
    check("a_lat", n, 3);
    check("a_code", kbd_data, 8'hC1);
    held = kbd_data;
    bad  = 0;
    for (int i = 0; i < 10000; i++) begin
      cyc();
      if (!kbd_strobe || kbd_data !== held) bad++;
    end
    check("hold_stable", bad, 0);
    press();
    wait_strobe(500, n);
    check("a_cgap", n, CG + 3);
    check("lf_code", kbd_data, 8'h8D);
    press();
    wait_idle(500, n, s);
    check("lf_lgap", n, LG + 1);
    check("a_extra", s, 0);
    check("a_keep", kbd_data, 8'h8D);

    // Control bytes and DEL skipped without pacing
    send(4, 8'h41, 8'h01, 8'h7F, 8'h42);
    wait_strobe(50, n);
    check("sk_code0", kbd_data, 8'hC1);
    press();
    wait_strobe(500, n);
    check("sk_lat", n, CG + 7);
    check("sk_code1", kbd_data, 8'hC2);
    press();
    wait_idle(500, n, s);
    check("sk_idle", n, CG + 1);
    check("sk_extra", s, 0);

    // CR,LF
    send(2, 8'h0D, 8'h0A, 8'h00, 8'h00);
    wait_strobe(50, n);
    check("crlf_c0", kbd_data, 8'h8D);
    press();
`ifdef TEXT_INJECT_CRLF_FOLD_EN
    wait_idle(500, n, s);
    check("crlf_idle", n, LG + 3);
    check("crlf_extra", s, 0);
`else
    wait_strobe(500, n);
    check("crlf_lat", n, LG + 3);
    check("crlf_c1", kbd_data, 8'h8D);
    press();
    wait_idle(500, n, s);
    check("crlf_idle", n, LG + 1);
    check("crlf_extra", s, 0);
`endif

    // Abort during GAP with a new "Z" download
    send(3, 8'h61, 8'h62, 8'h63, 8'h00);
    wait_strobe(50, n);
    check("ab_c0", kbd_data, 8'hC1);
    press();
    cyc(5);
    send(1, 8'h5A, 8'h00, 8'h00, 8'h00);
    wait_strobe(50, n);
    check("ab_lat", n, 3);
    check("ab_code", kbd_data, 8'hDA);
    press();
    wait_idle(500, n, s);
    check("ab_idle", n, CG + 1);
    check("ab_extra", s, 0);

    // Zero-length download
    send(0, 8'h00, 8'h00, 8'h00, 8'h00);
    check("z_busy1", busy, 1'b1);
    cyc();
    check("z_busy0", busy, 1'b0);
    cyc(5);
    check("z_strobe", kbd_strobe, 1'b0);

    // Stray write with download low
    wr   = 1'b1;
    addr = 13'd0;
    data = 8'h41;
    cyc();
    wr = 1'b0;
    cyc(5);
    check("stray_busy", busy, 1'b0);
    check("stray_strobe", kbd_strobe, 1'b0);

    // Reset while a key is presented
    send(1, 8'h62, 8'h00, 8'h00, 8'h00);
    wait_strobe(50, n);
    check("r_code", kbd_data, 8'hC2);
    #5 rst_n = 1'b0;
    #1;
    check("r_data", kbd_data, 8'h00);
    check("r_strobe", kbd_strobe, 1'b0);
    check("r_busy", busy, 1'b0);
    cyc();
    rst_n = 1'b1;
    s = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (kbd_strobe || busy) s++;
    end
    check("r_noreplay", s, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
